my_logic_gate_pipe: RTL and testbench



---
 rtl/my_logic_gate_pipe.sv | 148 ++++++++++++++
 tb/tb_my_logic_gate_pipe.sv | 322 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/my_logic_gate_pipe.sv
// Two-stage valid/ready pipeline reducing NUM_INPUTS operands bit-wise (AND/OR/XOR/NAND).
// Counts completed results. Defining MY_LOGIC_GATE_PIPE_PARITY_EN adds a registered parity_out.
module my_logic_gate_pipe #(
  parameter int DATA_WIDTH = 8,
  parameter int NUM_INPUTS = 4
) (
  input  logic                             clock_in,
  input  logic                             reset_in,
  input  logic [NUM_INPUTS*DATA_WIDTH-1:0] operands_in,
  input  logic [1:0]                       op_in,
  input  logic                             valid_in,
  output logic                             ready_out,
  output logic [DATA_WIDTH-1:0]            result_out,
  output logic                             valid_out,
  input  logic                             ready_in,
  input  logic                             count_clear_in,
  output logic [15:0]                      count_out
`ifdef MY_LOGIC_GATE_PIPE_PARITY_EN
  ,
  output logic                             parity_out
`endif
);

  typedef enum logic [1:0] {
    OP_AND  = 2'b00,
    OP_OR   = 2'b01,
    OP_XOR  = 2'b10,
    OP_NAND = 2'b11
  } op_e;

  logic                             s1_valid_q, s1_valid_d;
  logic [NUM_INPUTS*DATA_WIDTH-1:0] s1_operands_q, s1_operands_d;
  op_e                              s1_op_q, s1_op_d;
  logic                             s2_valid_q, s2_valid_d;
  logic [DATA_WIDTH-1:0]            s2_result_q, s2_result_d;
  logic [15:0]                      count_q, count_d;

  logic                             s2_free;
  logic                             accept;
  logic                             advance;
  logic                             out_fire;
  logic [DATA_WIDTH-1:0]            red_and;
  logic [DATA_WIDTH-1:0]            red_or;
  logic [DATA_WIDTH-1:0]            red_xor;
  logic [DATA_WIDTH-1:0]            reduced;

  // ready_out deliberately looks through S2 to ready_in so a full pipe keeps full throughput.
  always_comb begin
    s2_free   = !s2_valid_q || ready_in;
    ready_out = !s1_valid_q || s2_free;
    accept    = valid_in && ready_out;
    advance   = s1_valid_q && s2_free;
    out_fire  = s2_valid_q && ready_in;
  end

  always_comb begin
    red_and = '1;
    red_or  = '0;
    red_xor = '0;
    for (int k = 0; k < NUM_INPUTS; k++) begin
      red_and = red_and & s1_operands_q[k*DATA_WIDTH +: DATA_WIDTH];
      red_or  = red_or  | s1_operands_q[k*DATA_WIDTH +: DATA_WIDTH];
      red_xor = red_xor ^ s1_operands_q[k*DATA_WIDTH +: DATA_WIDTH];
    end
    reduced = red_and;
    case (s1_op_q)
      OP_AND:  reduced = red_and;
      OP_OR:   reduced = red_or;
      OP_XOR:  reduced = red_xor;
      OP_NAND: reduced = ~red_and;
    endcase
  end

  always_comb begin
    s1_valid_d    = s1_valid_q;
    s1_operands_d = s1_operands_q;
    s1_op_d       = s1_op_q;
    s2_valid_d    = s2_valid_q;
    s2_result_d   = s2_result_q;
    count_d       = count_q;

    if (accept) begin
      s1_valid_d    = 1'b1;
      s1_operands_d = operands_in;
      s1_op_d       = op_e'(op_in);
    end else if (advance) begin
      s1_valid_d = 1'b0;
    end

    if (advance) begin
      s2_valid_d  = 1'b1;
      s2_result_d = reduced;
    end else if (out_fire) begin
      s2_valid_d = 1'b0;
    end

    // A clear in the same cycle as a handshake still leaves the counter at zero.
    if (count_clear_in) begin
      count_d = '0;
    end else if (out_fire) begin
      count_d = count_q + 16'd1;
    end
  end

  always_ff @(posedge clock_in) begin
    if (reset_in) begin
      s1_valid_q    <= 1'b0;
      s1_operands_q <= '0;
      s1_op_q       <= OP_AND;
      s2_valid_q    <= 1'b0;
      s2_result_q   <= '0;
      count_q       <= '0;
    end else begin
      s1_valid_q    <= s1_valid_d;
      s1_operands_q <= s1_operands_d;
      s1_op_q       <= s1_op_d;
      s2_valid_q    <= s2_valid_d;
      s2_result_q   <= s2_result_d;
      count_q       <= count_d;
    end
  end

  assign valid_out  = s2_valid_q;
  assign result_out = s2_result_q;
  assign count_out  = count_q;

`ifdef MY_LOGIC_GATE_PIPE_PARITY_EN
  logic parity_q, parity_d;

  always_comb begin
    parity_d = parity_q;
    if (advance) begin
      parity_d = ^reduced;
    end
  end

  always_ff @(posedge clock_in) begin
    if (reset_in) begin
      parity_q <= 1'b0;
    end else begin
      parity_q <= parity_d;
    end
  end

  assign parity_out = parity_q;
`endif

endmodule

// File: tb/tb_my_logic_gate_pipe.sv
// Bench for my_logic_gate_pipe: queue-based reference model checked every cycle, plus literal
// expectations for the directed scenarios and a 2x1-bit instance for the single-bit AND case.
module tb_my_logic_gate_pipe;

  localparam int DW = 8;
  localparam int NI = 4;
  localparam logic [NI*DW-1:0] OPS = {8'hF0, 8'h3C, 8'h0F, 8'hFF};

  logic              clock_in = 1'b0;
  logic              reset_in = 1'b1;
  logic [NI*DW-1:0]  operands_in = '0;
  logic [1:0]        op_in = 2'b00;
  logic              valid_in = 1'b0;
  logic              ready_out;
  logic [DW-1:0]     result_out;
  logic              valid_out;
  logic              ready_in = 1'b1;
  logic              count_clear_in = 1'b0;
  logic [15:0]       count_out;

  logic [1:0]        b_ops = 2'b00;
  logic              b_valid = 1'b0;
  logic              b_ready_out;
  logic [0:0]        b_result;
  logic              b_valid_out;
  logic              b_ready_in = 1'b1;
  logic [15:0]       b_count;

`ifdef MY_LOGIC_GATE_PIPE_PARITY_EN
  logic              parity_out;
  logic              b_parity;
`endif

  always #5 clock_in = ~clock_in;

  my_logic_gate_pipe #(.DATA_WIDTH(DW), .NUM_INPUTS(NI)) dut (
    .clock_in(clock_in), .reset_in(reset_in), .operands_in(operands_in), .op_in(op_in),
    .valid_in(valid_in), .ready_out(ready_out), .result_out(result_out), .valid_out(valid_out),
    .ready_in(ready_in), .count_clear_in(count_clear_in), .count_out(count_out)
`ifdef MY_LOGIC_GATE_PIPE_PARITY_EN
    , .parity_out(parity_out)
`endif
  );

  my_logic_gate_pipe #(.DATA_WIDTH(1), .NUM_INPUTS(2)) dut_bit (
    .clock_in(clock_in), .reset_in(reset_in), .operands_in(b_ops), .op_in(2'b00),
    .valid_in(b_valid), .ready_out(b_ready_out), .result_out(b_result), .valid_out(b_valid_out),
    .ready_in(b_ready_in), .count_clear_in(1'b0), .count_out(b_count)
`ifdef MY_LOGIC_GATE_PIPE_PARITY_EN
    , .parity_out(b_parity)
`endif
  );

  int tests_run = 0;
  int tests_failed = 0;
  int cycle = 0;
  int accept_cnt = 0;
  logic [DW-1:0] exp_q[$];
  bit            head_in_s2 = 1'b0;
  logic [15:0]   exp_count = 16'h0;
  logic [DW-1:0] got_q[$];
  int            got_cyc[$];
  logic          got_par[$];

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    tests_run++;
    if (actual !== expected) begin
      tests_failed++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
    end
  endtask

  // Per bit, count the ones across operands and apply the operation's rule to that count.
  function automatic logic [DW-1:0] reduceModel(input logic [NI*DW-1:0] ops, input logic [1:0] op);
    logic [DW-1:0] r;
    int ones;
    r = '0;
    for (int i = 0; i < DW; i++) begin
      ones = 0;
      for (int k = 0; k < NI; k++) ones += int'(ops[k*DW + i]);
      case (op)
        2'b00:   r[i] = (ones == NI);
        2'b01:   r[i] = (ones != 0);
        2'b10:   r[i] = (ones % 2 == 1);
        default: r[i] = (ones != NI);
      endcase
    end
    return r;
  endfunction

  always @(posedge clock_in) cycle++;

  // Compare process: check outputs against the model, then advance the model for the coming edge.
  always @(negedge clock_in) begin : monitor
    bit hs;
    bit exp_ready;
    if (reset_in) begin
      exp_q.delete();
      head_in_s2 = 1'b0;
      exp_count  = 16'h0;
    end else begin
      exp_ready = !(exp_q.size() == 2 && !ready_in);
      checkOutput("valid_out", valid_out, head_in_s2);
      checkOutput("ready_out", ready_out, exp_ready);
      checkOutput("count_out", count_out, exp_count);
      if (head_in_s2) begin
        checkOutput("result_out", result_out, exp_q[0]);
`ifdef MY_LOGIC_GATE_PIPE_PARITY_EN
        checkOutput("parity_out", parity_out, ^exp_q[0]);
`endif
      end
      hs = head_in_s2 && ready_in;
      if (hs) begin
        got_q.push_back(result_out);
        got_cyc.push_back(cycle);
`ifdef MY_LOGIC_GATE_PIPE_PARITY_EN
        got_par.push_back(parity_out);
`else
        got_par.push_back(1'b0);
`endif
        void'(exp_q.pop_front());
        head_in_s2 = 1'b0;
      end
      if (!head_in_s2 && exp_q.size() != 0) head_in_s2 = 1'b1;
      if (valid_in && exp_ready) begin
        exp_q.push_back(reduceModel(operands_in, op_in));
        accept_cnt++;
      end
      exp_count = count_clear_in ? 16'h0 : exp_count + (hs ? 16'h1 : 16'h0);
    end
  end

  // Called just after a rising edge; returns just after the edge that accepted the transfer.
  task automatic applyStimulus(input logic [NI*DW-1:0] ops, input logic [1:0] op);
    int waited;
    waited = 0;
    operands_in = ops;
    op_in       = op;
    valid_in    = 1'b1;
    @(negedge clock_in);
    while (!ready_out && waited < 100) begin
      waited++;
      @(negedge clock_in);
    end
    if (!ready_out) checkOutput("accept_timeout", 32'(ready_out), 32'd1);
    @(posedge clock_in); #1;
    valid_in = 1'b0;
  endtask

  task automatic waitIdle();
    int n;
    n = 0;
    @(negedge clock_in); #1;
    while ((valid_out || exp_q.size() != 0) && n < 200) begin
      n++;
      @(negedge clock_in); #1;
    end
    if (n >= 200) checkOutput("drain_timeout", 32'(n), 32'd0);
    @(posedge clock_in); #1;
  endtask

  initial begin : watchdog
    #5_000_000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin : main
    int base;
    int a0;
    repeat (3) @(posedge clock_in);
    #1 reset_in = 1'b0;
    @(negedge clock_in);
    checkOutput("rst_valid_out", valid_out, 0);
    checkOutput("rst_result_out", result_out, 0);
    checkOutput("rst_count_out", count_out, 0);
    checkOutput("rst_ready_out", ready_out, 1);
`ifdef MY_LOGIC_GATE_PIPE_PARITY_EN
    checkOutput("rst_parity_out", parity_out, 0);
`endif
    @(posedge clock_in); #1;

    // 1: single AND transfer, two-cycle latency, one-cycle valid pulse
    applyStimulus(OPS, 2'b00);
    @(negedge clock_in);
    checkOutput("t1_not_early", valid_out, 0);
    @(negedge clock_in);
    checkOutput("t1_valid", valid_out, 1);
    checkOutput("t1_result", result_out, 8'h00);
    @(negedge clock_in);
    checkOutput("t1_pulse_once", valid_out, 0);
    checkOutput("t1_count", count_out, 1);
    @(posedge clock_in); #1;

    // 2: OR, XOR, NAND back-to-back
    base = got_q.size();
    applyStimulus(OPS, 2'b01);
    applyStimulus(OPS, 2'b10);
    applyStimulus(OPS, 2'b11);
    waitIdle();
    checkOutput("t2_n", got_q.size() - base, 3);
    if (got_q.size() - base == 3) begin
      checkOutput("t2_or", got_q[base], 8'hFF);
      checkOutput("t2_xor", got_q[base+1], 8'h3C);
      checkOutput("t2_nand", got_q[base+2], 8'hFF);
      checkOutput("t2_consecutive_a", got_cyc[base+1] - got_cyc[base], 1);
      checkOutput("t2_consecutive_b", got_cyc[base+2] - got_cyc[base+1], 1);
`ifdef MY_LOGIC_GATE_PIPE_PARITY_EN
      checkOutput("t2_par0", got_par[base], 0);
      checkOutput("t2_par1", got_par[base+1], 0);
      checkOutput("t2_par2", got_par[base+2], 0);
`endif
    end

    // 3: backpressure, exactly two buffered, release accepts the third in the same cycle
    base = got_q.size();
    a0 = accept_cnt;
    ready_in = 1'b0;
    operands_in = OPS; op_in = 2'b01; valid_in = 1'b1;
    @(posedge clock_in); #1 op_in = 2'b10;
    @(posedge clock_in); #1 op_in = 2'b00;
    @(negedge clock_in);
    checkOutput("t3_full_ready", ready_out, 0);
    @(posedge clock_in); #1;
    @(negedge clock_in); #1;
    checkOutput("t3_accepted_two", accept_cnt - a0, 2);
    checkOutput("t3_held_ready", ready_out, 0);
    @(posedge clock_in); #1 ready_in = 1'b1;
    @(negedge clock_in);
    checkOutput("t3_release_ready", ready_out, 1);
    @(posedge clock_in); #1 valid_in = 1'b0;
    waitIdle();
    checkOutput("t3_accepted_three", accept_cnt - a0, 3);
    checkOutput("t3_n", got_q.size() - base, 3);
    if (got_q.size() - base == 3) begin
      checkOutput("t3_first", got_q[base], 8'hFF);
      checkOutput("t3_second", got_q[base+1], 8'h3C);
      checkOutput("t3_third", got_q[base+2], 8'h00);
    end

    // 4: clear, 65535 transfers to 0xFFFF, one more wraps, clear beats a handshake
    count_clear_in = 1'b1;
    @(posedge clock_in); #1 count_clear_in = 1'b0;
    @(negedge clock_in);
    checkOutput("t4_cleared", count_out, 0);
    @(posedge clock_in); #1;
    valid_in = 1'b1;
    repeat (65535) begin
      operands_in = $urandom;
      op_in = 2'($urandom_range(0, 3));
      @(posedge clock_in); #1;
    end
    valid_in = 1'b0;
    waitIdle();
    checkOutput("t4_ffff", count_out, 16'hFFFF);
    applyStimulus(OPS, 2'b01);
    waitIdle();
    checkOutput("t4_wrap", count_out, 16'h0000);
    applyStimulus(OPS, 2'b10);
    waitIdle();
    checkOutput("t4_one", count_out, 16'h0001);
    applyStimulus(OPS, 2'b00);
    @(posedge clock_in); #1 count_clear_in = 1'b1;
    @(negedge clock_in);
    checkOutput("t4_hs_pending", valid_out & ready_in, 1);
    @(posedge clock_in); #1 count_clear_in = 1'b0;
    @(negedge clock_in);
    checkOutput("t4_clear_wins", count_out, 0);
    @(posedge clock_in); #1;

    // 5: reset with both stages full
    applyStimulus(OPS, 2'b00);
    waitIdle();
    ready_in = 1'b0;
    operands_in = OPS; op_in = 2'b11; valid_in = 1'b1;
    @(posedge clock_in); #1;
    @(posedge clock_in); #1;
    @(negedge clock_in);
    checkOutput("t5_full_valid", valid_out, 1);
    checkOutput("t5_full_ready", ready_out, 0);
    @(posedge clock_in); #1 reset_in = 1'b1; valid_in = 1'b0;
    @(posedge clock_in); #1 reset_in = 1'b0;
    @(negedge clock_in); #1;
    checkOutput("t5_valid_out", valid_out, 0);
    checkOutput("t5_result_out", result_out, 0);
    checkOutput("t5_count_out", count_out, 0);
    checkOutput("t5_ready_out", ready_out, 1);
`ifdef MY_LOGIC_GATE_PIPE_PARITY_EN
    checkOutput("t5_parity_out", parity_out, 0);
`endif
    base = got_q.size();
    ready_in = 1'b1;
    repeat (6) @(negedge clock_in);
    #1;
    checkOutput("t5_no_stale", got_q.size() - base, 0);
    checkOutput("t5_still_idle", valid_out, 0);
    @(posedge clock_in); #1;

    // 6: single-bit, two-operand AND
    for (int v = 0; v < 4; v++) begin
      logic [1:0] vec_in [4];
      logic       vec_exp [4];
      vec_in  = '{2'b00, 2'b10, 2'b01, 2'b11};
      vec_exp = '{1'b0, 1'b0, 1'b0, 1'b1};
      b_ops = vec_in[v];
      b_valid = 1'b1;
      @(negedge clock_in);
      checkOutput($sformatf("t6_ready_%0d", v), b_ready_out, 1);
      @(posedge clock_in); #1 b_valid = 1'b0;
      @(negedge clock_in);
      checkOutput($sformatf("t6_early_%0d", v), b_valid_out, 0);
      @(negedge clock_in);
      checkOutput($sformatf("t6_valid_%0d", v), b_valid_out, 1);
      checkOutput($sformatf("t6_result_%0d", v), b_result, vec_exp[v]);
      @(posedge clock_in); #1;
    end

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
